cmp_search_initiator: RTL and testbench
=======================================

Name: cmp_search_initiator

Overview:
- Sequential initiator that drives an external magnitude comparator. It presents probe values on the comparator's b input and consumes the greater-than / less-than response for an unknown value held on the comparator's a input.
- Runs a binary search to recover that hidden value, or reports it not found when the responses are inconsistent.
- Sits on the requesting side of the existing comparator/logic-unit datapath and reuses its gt/lt outputs unchanged.

Parameters:
- WIDTH, 3, bit width of the searched value, the probe and the result (legal range 2..8).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new search; sampled on the rising edge while in IDLE or DONE.
- a_gt_b  input  1  comparator response: hidden value > probe.
- a_lt_b  input  1  comparator response: hidden value < probe.
- probe  output  WIDTH  value driven to the comparator b input.
- probe_valid  output  1  high while probe is meaningful (PROBE state).
- busy  output  1  high in PROBE state.
- done  output  1  high in DONE state; held until the next accepted start.
- found  output  1  valid while done=1; 1 means the value was located.
- error  output  1  valid while done=1; 1 means a_gt_b and a_lt_b were both high on a sampled edge.
- result  output  WIDTH  located value, valid while done=1 and found=1; otherwise 0.
- probe_count  output  WIDTH+1  number of probes issued in the current or last search.

Behaviour:
- Reset (async, any state): state=IDLE, lo=0, hi=0, and every output 0 (probe, probe_valid, busy, done, found, error, result, probe_count).
- The only accepted Already decided interface rule: one clock; reset is asynchronous and active-high.
- States: IDLE, PROBE, DONE.
- IDLE, or DONE with start=1 at the edge:
  - lo<=0, hi<=2^WIDTH-1, probe_count<=0.
  - done, found, error and result are cleared.
  - Next state is PROBE.
- IDLE or DONE with start=0: hold state and all outputs.
- PROBE:
  - probe = (lo+hi)>>1, computed in WIDTH+1 bits and truncated to WIDTH. It is a combinational function of the registered lo and hi.
  - probe_valid=1 and busy=1.
  - The comparator response is sampled on each rising edge, one probe per cycle, with probe_count incremented by 1.
- Response decode at the PROBE edge, in priority order:
  - a_gt_b=1 and a_lt_b=1: go to DONE with error=1, found=0.
  - Both 0 (equal): go to DONE with found=1, result=probe.
  - a_gt_b=1: if probe==hi, go to DONE with found=0; else lo<=probe+1.
  - a_lt_b=1: if probe==lo, go to DONE with found=0; else hi<=probe-1.
  - lo and hi never underflow or overflow; the boundary checks above terminate the search first.
- Latency:
  - The start edge is edge 0.
  - The k-th probe is sampled at edge k.
  - done rises after the edge of the terminating probe.
  - Maximum WIDTH+1 probes (4 for WIDTH=3).
- start asserted while in PROBE is ignored; the search is not restarted.
- start held high in DONE immediately begins a new search on the next edge (back-to-back searches allowed).
- Reset asserted mid-search aborts immediately. After reset releases, the block stays in IDLE until a new start.
- probe is 0 whenever probe_valid=0.

Test Plan:
- WIDTH=3, hidden=3, ideal comparator, start pulse:
  - Probes issued: 3 (equal), so 1 probe.
  - Required: done=1, found=1, result=3, probe_count=1, one cycle after the start edge.
- Hidden=0:
  - Probes issued: 3 (lt), 1 (lt), 0 (eq).
  - Required: found=1, result=0, probe_count=3.
  - lo/hi never wrap.
- Hidden=7:
  - Probes issued: 3, 5, 6, 7 (gt, gt, gt, eq).
  - Required: found=1, result=7, probe_count=4 (worst case).
- Responder stuck at a_lt_b=1:
  - Probes issued: 3, 1, 0.
  - Required: done=1, found=0, error=0, result=0, probe_count=3.
- a_gt_b=a_lt_b=1 on the first probe:
  - Required: done=1, error=1, found=0 after 1 probe.
  - A following start with an ideal comparator and hidden=5 gives probes 3, 5, then found=1, result=5, with error cleared.
- Mid-search disruptions, hidden=6:
  - start asserted again after the first probe is ignored; probe sequence 3, 5, 6 is unchanged.
  - In a repeat run, reset pulsed after the second probe makes all outputs 0 asynchronously, with state IDLE and no further probes until start.

Source files
------------

// File: rtl/cmp_search_initiator.sv
// Binary-search initiator for an external magnitude comparator: walks probe
// values on the comparator b input until the hidden a value is located or ruled out.
module cmp_search_initiator #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    output logic [WIDTH-1:0] probe,
    output logic             probe_valid,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH:0]   probe_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   cnt_q, cnt_d;

    // Midpoint needs the extra carry bit so lo+hi cannot wrap before the shift.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mid;

    assign sum = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid = sum[WIDTH:1];

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        busy_d   = busy_q;
        done_d   = done_q;
        found_d  = found_q;
        error_d  = error_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_PROBE;
                    lo_d     = '0;
                    hi_d     = '1;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                end
            end
            S_PROBE: begin
                cnt_d = cnt_q + 1'b1;
                if (a_gt_b && a_lt_b) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else if (!a_gt_b && !a_lt_b) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    found_d  = 1'b1;
                    result_d = mid;
                end else if (a_gt_b) begin
                    // Hitting the range edge ends the search before lo can overflow.
                    if (mid == hi_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        lo_d = mid + 1'b1;
                    end
                end else begin
                    if (mid == lo_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        hi_d = mid - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            error_q  <= error_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign probe       = busy_q ? mid : '0;
    assign probe_valid = busy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign error       = error_q;
    assign result      = result_q;
    assign probe_count = cnt_q;

endmodule

// File: tb/tb_cmp_search_initiator.sv
// Scoreboard bench: a behavioural binary-search model queues expected probes and
// outcomes; a negedge monitor pops and compares whatever the DUT presents.
module tb_cmp_search_initiator;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         a_gt_b, a_lt_b;
    logic [W-1:0] probe;
    logic         probe_valid, busy, done, found, error;
    logic [W-1:0] result;
    logic [W:0]   probe_count;

    // responder modes: 0 ideal, 1 stuck lt, 2 both high, 3 stuck gt
    int mode = 0;
    int hidden = 0;

    typedef struct {
        bit found;
        bit err;
        int res;
        int cnt;
    } exp_t;

    int   exp_probe[$];
    exp_t exp_res[$];
    int   npass = 0;
    int   ntot = 0;
    bit   done_prev = 1'b0;

    cmp_search_initiator #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b),
        .probe(probe), .probe_valid(probe_valid), .busy(busy),
        .done(done), .found(found), .error(error),
        .result(result), .probe_count(probe_count)
    );

    always #5 clk = ~clk;

    assign a_gt_b = (mode == 2) || (mode == 3) || (mode == 0 && hidden > int'(probe));
    assign a_lt_b = (mode == 1) || (mode == 2) || (mode == 0 && hidden < int'(probe));

    task automatic chk(input string name, input int act, input int req);
        ntot++;
        if (act == req) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Plain integer binary search over [0, 2^W-1] with the same responder rules.
    task automatic model_push(input int m, input int hid, output int cnt);
        int   lo, hi, p;
        bit   gt, lt;
        exp_t e;
        lo = 0;
        hi = (1 << W) - 1;
        cnt = 0;
        e = '{found: 0, err: 0, res: 0, cnt: 0};
        forever begin
            p = (lo + hi) / 2;
            exp_probe.push_back(p);
            cnt++;
            gt = (m == 2) || (m == 3) || (m == 0 && hid > p);
            lt = (m == 1) || (m == 2) || (m == 0 && hid < p);
            if (gt && lt) begin
                e.err = 1;
                break;
            end else if (!gt && !lt) begin
                e.found = 1;
                e.res = p;
                break;
            end else if (gt) begin
                if (p == hi) break;
                lo = p + 1;
            end else begin
                if (p == lo) break;
                hi = p - 1;
            end
        end
        e.cnt = cnt;
        exp_res.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            done_prev <= 1'b0;
        end else begin
            if (probe_valid) begin
                chk("busy_with_probe", int'(busy), 1);
                if (exp_probe.size() == 0) chk("unexpected_probe", int'(probe), -1);
                else chk("probe", int'(probe), exp_probe.pop_front());
            end else begin
                chk("probe_idle_zero", int'(probe), 0);
            end
            if (done && !done_prev) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_res.pop_front();
                    chk("found", int'(found), int'(e.found));
                    chk("error", int'(error), int'(e.err));
                    chk("result", int'(result), e.res);
                    chk("probe_count", int'(probe_count), e.cnt);
                end
            end
            done_prev <= done;
        end
    end

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input int m, input int hid, input bit hold_check);
        int cnt, cyc;
        logic [W-1:0] r;
        @(negedge clk);
        mode = m;
        hidden = hid;
        model_push(m, hid, cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("latency", cyc, cnt);
        if (hold_check) begin
            r = result;
            repeat (2) @(negedge clk);
            chk("done_held", int'(done), 1);
            chk("result_held", int'(result), int'(r));
            chk("busy_in_done", int'(busy), 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, int'({probe, probe_valid, busy, done, found, error, result}), 0);
        chk({tag, "_count"}, int'(probe_count), 0);
    endtask

    initial begin
        int cyc;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("idle_after_reset");

        run(0, 3, 1'b1);
        run(0, 0, 1'b1);
        run(0, 7, 1'b1);
        run(1, 0, 1'b1);
        run(3, 0, 1'b0);

        // Error search, then start held through DONE for a back-to-back ideal search.
        @(negedge clk);
        mode = 2;
        model_push(2, 0, cyc);
        model_push(0, 5, cyc);
        start = 1'b1;
        @(negedge clk);
        wait_done(cyc);
        mode = 0;
        hidden = 5;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        chk("error_cleared", int'(error), 0);
        wait_done(cyc);

        // start re-asserted during PROBE must not restart the search.
        @(negedge clk);
        mode = 0;
        hidden = 6;
        model_push(0, 6, cyc);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);

        // Reset mid-search, after the second probe has been sampled.
        @(negedge clk);
        exp_probe.push_back(3);
        exp_probe.push_back(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("probes_before_reset", exp_probe.size(), 0);
        chk_all_zero("idle_no_restart");

        for (int i = 0; i < 24; i++) begin
            int m;
            m = ($urandom_range(0, 5) < 4) ? 0 : int'($urandom_range(1, 3));
            run(m, int'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 1) == 1));
        end

        repeat (2) @(negedge clk);
        chk("leftover_probes", exp_probe.size(), 0);
        chk("leftover_results", exp_res.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
